// File: rtl/fpu_add_arbiter_pkg.sv
// Shared types for the FPU adder arbiter slice.
// Tag ids are sized for the largest supported requester count.
package fpu_arb_pkg;

  localparam int FP_W = 32;
  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } fp_state_e;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fpu_add_arbiter_if.sv
// Requester, adder and response signals of the shared-adder arbiter.
// Optional counters appear when FPU_ARB_STAT_EN is defined.
interface fpu_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  import fpu_arb_pkg::*;

  logic [N_REQ-1:0]      req_vld;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic [N_REQ-1:0]      req_rdy;
  logic                  hold;

  logic                  add_vld;
  logic [FP_W-1:0]       add_a;
  logic [FP_W-1:0]       add_b;
  logic [FP_W-1:0]       add_res;
  fp_state_e             add_state;
  logic                  add_res_vld;

  logic                  rsp_vld;
  logic [ID_W-1:0]       rsp_id;
  logic [FP_W-1:0]       rsp_res;
  fp_state_e             rsp_state;
  logic                  busy;
  logic                  seq_err;
`ifdef FPU_ARB_STAT_EN
  logic [N_REQ*16-1:0]   grant_cnt;
  logic [15:0]           stall_cnt;
`endif

  modport slave (
    input  req_vld, req_a, req_b, hold,
    input  add_res, add_state, add_res_vld,
    output req_rdy, add_vld, add_a, add_b,
    output rsp_vld, rsp_id, rsp_res, rsp_state,
`ifdef FPU_ARB_STAT_EN
    output grant_cnt, stall_cnt,
`endif
    output busy, seq_err
  );

  modport master (
    output req_vld, req_a, req_b, hold,
    output add_res, add_state, add_res_vld,
    input  req_rdy, add_vld, add_a, add_b,
    input  rsp_vld, rsp_id, rsp_res, rsp_state,
`ifdef FPU_ARB_STAT_EN
    input  grant_cnt, stall_cnt,
`endif
    input  busy, seq_err
  );

endinterface

// File: rtl/fpu_add_arbiter_rr_arbiter.sv
// Round-robin grant: first requester at or after ptr wins.
// Pure combinational; en gates every grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (en && !any && req[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one pipelined FP adder among N_REQ requesters, tagging results.
// Define FPU_ARB_STAT_EN for per-requester grant and stall counters.
module fpu_add_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 6,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst,
  fpu_add_arbiter_if.slave bus
);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             hs;
  logic [ID_W-1:0]  rr_ptr;

  logic                add_vld_q;
  logic [FP_W-1:0]     add_a_q;
  logic [FP_W-1:0]     add_b_q;
  logic [ID_MAX_W-1:0] iss_id;

  tag_t tag_q [ADD_LAT];
  tag_t tag_last;

  logic            rsp_vld_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [FP_W-1:0] rsp_res_q;
  fp_state_e       rsp_state_q;
  logic            seq_err_q;
  logic            bsy;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
    .req     (bus.req_vld),
    .ptr     (rr_ptr),
    .en      (!rst && !bus.hold),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (hs)
  );

  assign bus.req_rdy = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (hs) begin
      if (gnt_idx == ID_W'(N_REQ - 1)) rr_ptr <= '0;
      else                             rr_ptr <= gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_vld_q <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      iss_id    <= '0;
    end else begin
      add_vld_q <= hs;
      if (hs) begin
        add_a_q <= bus.req_a[FP_W*int'(gnt_idx) +: FP_W];
        add_b_q <= bus.req_b[FP_W*int'(gnt_idx) +: FP_W];
        iss_id  <= ID_MAX_W'(gnt_idx);
      end
    end
  end

  assign bus.add_vld = add_vld_q;
  assign bus.add_a   = add_a_q;
  assign bus.add_b   = add_b_q;

  // Last stage lines up with add_res_vld of the same operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{valid: add_vld_q, id: iss_id};
      for (int k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign tag_last = tag_q[ADD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_res_q   <= '0;
      rsp_state_q <= OK;
      seq_err_q   <= 1'b0;
    end else begin
      rsp_vld_q <= tag_last.valid;
      if (tag_last.valid) begin
        rsp_id_q    <= tag_last.id[ID_W-1:0];
        rsp_res_q   <= bus.add_res;
        rsp_state_q <= bus.add_state;
      end
      if (bus.add_res_vld != tag_last.valid) seq_err_q <= 1'b1;
    end
  end

  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_state = rsp_state_q;
  assign bus.seq_err   = seq_err_q;

  // Stays up through the response cycle so drain ends after it.
  always_comb begin
    bsy = add_vld_q | rsp_vld_q;
    for (int k = 0; k < ADD_LAT; k++) bsy = bsy | tag_q[k].valid;
  end

  assign bus.busy = bsy;

`ifdef FPU_ARB_STAT_EN
  logic [N_REQ*16-1:0] grant_cnt_q;
  logic [15:0]         stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && grant_cnt_q[16*i +: 16] != 16'hFFFF)
          grant_cnt_q[16*i +: 16] <= grant_cnt_q[16*i +: 16] + 16'd1;
      end
      if (|bus.req_vld && !bus.hold && !hs && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.grant_cnt = grant_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter with a behavioural 6-stage adder.
// Expected values are hand-computed IEEE-754 single constants.
module tb_fpu_add_arbiter;
  import fpu_arb_pkg::*;

  localparam int N_REQ   = 4;
  localparam int ADD_LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic drop_arm = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_add_arbiter_if #(.N_REQ(N_REQ)) bus ();

  fpu_add_arbiter #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [ADD_LAT-1:0] mv;
  logic [31:0]        mr [ADD_LAT];

  always @(posedge clk) begin
    if (rst) begin
      mv <= '0;
    end else begin
      mv    <= {mv[ADD_LAT-2:0], bus.add_vld & !drop_arm};
      mr[0] <= r2sp(sp2r(bus.add_a) + sp2r(bus.add_b));
      for (int k = 1; k < ADD_LAT; k++) mr[k] <= mr[k-1];
    end
  end

  assign bus.add_res_vld = mv[ADD_LAT-1];
  assign bus.add_res     = mr[ADD_LAT-1];
  assign bus.add_state   = (mr[ADD_LAT-1] == 32'd0) ? NUL : OK;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          c;
  } rsp_t;
  rsp_t rq [$];

  always @(negedge clk) begin
    if (!rst && bus.rsp_vld)
      rq.push_back('{id: int'(bus.rsp_id), res: bus.rsp_res, c: cyc});
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  logic [31:0] res_tab [N_REQ];
  int g0, last, fall;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_tab[0] = 32'h3FC00000;
    res_tab[1] = 32'h40200000;
    res_tab[2] = 32'h40600000;
    res_tab[3] = 32'h40900000;
    bus.hold    = 1'b0;
    bus.req_vld = 4'b0100;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.req_a[64 +: 32] = 32'h3F800000;
    bus.req_b[64 +: 32] = 32'h40000000;

    // reset state, with a request pending under reset
    tick; tick;
    smp;
    chk("rst_rdy", bus.req_rdy, 0);
    chk("rst_add_vld", bus.add_vld, 0);
    chk("rst_add_a", bus.add_a, 0);
    chk("rst_add_b", bus.add_b, 0);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_res", bus.rsp_res, 0);
    chk("rst_seq_err", bus.seq_err, 0);
    chk("rst_busy", bus.busy, 0);
    tick;
    rst = 1'b0;

    // single request from requester 2
    smp;
    chk("single_rdy", bus.req_rdy, 4'b0100);
    tick;
    bus.req_vld = '0;
    smp;
    chk("single_add_vld", bus.add_vld, 1);
    chk("single_add_a", bus.add_a, 32'h3F800000);
    chk("single_add_b", bus.add_b, 32'h40000000);
    repeat (6) smp;
    chk("single_early", bus.rsp_vld, 0);
    smp;
    chk("single_rsp_vld", bus.rsp_vld, 1);
    chk("single_rsp_id", bus.rsp_id, 2);
    chk("single_rsp_res", bus.rsp_res, 32'h40400000);
    chk("single_rsp_state", bus.rsp_state, OK);
    tick;

    // all four continuously, pointer restarted at 0
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a[32*i +: 32] = 32'h3F800000 + (i == 0 ? 32'h0 :
                              i == 1 ? 32'h00800000 :
                              i == 2 ? 32'h00C00000 : 32'h01000000);
      bus.req_b[32*i +: 32] = 32'h3F000000;
    end
    rq.delete();
    bus.req_vld = 4'hF;
    g0 = -1;
    for (int k = 0; k < 8; k++) begin
      smp;
      if (g0 < 0) g0 = cyc;
      chk($sformatf("rr_all_g%0d", k), bus.req_rdy, 4'b0001 << (k % 4));
      tick;
    end
    bus.req_vld = '0;
    repeat (20) tick;
    chk("rr_all_count", rq.size(), 8);
    if (rq.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("rr_all_id%0d", k), rq[k].id, k % 4);
        chk($sformatf("rr_all_res%0d", k), rq[k].res, res_tab[k % 4]);
      end
      chk("rr_all_b2b", rq[7].c - rq[0].c, 7);
      chk("rr_all_lat", rq[0].c - g0, ADD_LAT + 2);
    end

    // move pointer to 2, then only 0 and 3 request
    bus.req_vld = 4'b0010;
    smp;
    chk("ptr_setup", bus.req_rdy, 4'b0010);
    tick;
    bus.req_vld = 4'b1001;
    smp;
    chk("ptr_first", bus.req_rdy, 4'b1000);
    tick;
    bus.req_vld = 4'b0001;
    smp;
    chk("ptr_second", bus.req_rdy, 4'b0001);
    tick;
    bus.req_vld = '0;
    repeat (12) tick;

    // hold with three operations in flight
    rq.delete();
    bus.req_vld = 4'hF;
    repeat (3) tick;
    bus.hold = 1'b1;
    smp;
    chk("hold_rdy", bus.req_rdy, 0);
    chk("hold_busy", bus.busy, 1);
    last = -1;
    fall = -1;
    for (int k = 0; k < 20; k++) begin
      smp;
      if (bus.rsp_vld) last = cyc;
      if (!bus.busy && fall < 0 && last >= 0) fall = cyc;
    end
    tick;
    bus.hold    = 1'b0;
    bus.req_vld = '0;
    chk("hold_count", rq.size(), 3);
    chk("hold_busy_fall", fall - last, 1);
    if (rq.size() == 3) begin
      chk("hold_id0", rq[0].id, 1);
      chk("hold_id2", rq[2].id, 3);
    end

    // adder drops one result valid
    bus.req_a[31:0] = 32'h3F800000;
    bus.req_b[31:0] = 32'h40000000;
    bus.req_vld = 4'b0001;
    smp;
    chk("drop_rdy", bus.req_rdy, 4'b0001);
    tick;
    bus.req_vld = '0;
    drop_arm = 1'b1;
    smp;
    tick;
    drop_arm = 1'b0;
    repeat (6) smp;
    chk("drop_err_pre", bus.seq_err, 0);
    smp;
    chk("drop_err", bus.seq_err, 1);
    chk("drop_rsp_vld", bus.rsp_vld, 1);
    chk("drop_rsp_res", bus.rsp_res, 32'h40400000);
    repeat (3) smp;
    chk("drop_sticky", bus.seq_err, 1);
    tick;

    // reset with four operations in flight
    bus.req_vld = 4'hF;
    repeat (4) tick;
    bus.req_vld = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    rq.delete();
    smp;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_seq_err", bus.seq_err, 0);
    repeat (15) tick;
    chk("mrst_no_rsp", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
